// File: rtl/vcve2_vrf_mem_arbiter.sv
// Round-robin arbiter sharing one OBI data port among NumReq requesters.
// A request that is presented but not yet granted is locked, and an in-order ID FIFO routes each response back to its issuer.
module vcve2_vrf_mem_arbiter #(
  parameter int NumReq         = 2,
  parameter int MaxOutstanding = 2,
  localparam int IdW           = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_i,
  output logic [NumReq-1:0]      gnt_o,
  output logic [NumReq-1:0]      rvalid_o,
  output logic [NumReq-1:0]      err_o,
  input  logic [NumReq-1:0]      we_i,
  input  logic [NumReq*4-1:0]    be_i,
  input  logic [NumReq*32-1:0]   addr_i,
  input  logic [NumReq*32-1:0]   wdata_i,
  output logic [31:0]            rdata_o,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  input  logic                   data_rvalid_i,
  input  logic                   data_err_i,
  output logic                   data_we_o,
  output logic [3:0]             data_be_o,
  output logic [31:0]            data_addr_o,
  output logic [31:0]            data_wdata_o,
  input  logic [31:0]            data_rdata_i,
  output logic                   busy_o,
  output logic                   spurious_o
);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {ARB, LOCK} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_q, rr_d, lock_q, lock_d;
  logic [IdW-1:0]  fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            spurious_q;

  logic [IdW-1:0]  win, sel, head;
  logic            win_vld, push, pop;

  function automatic logic [IdW-1:0] id_inc(input logic [IdW-1:0] id);
    return (int'(id) == NumReq - 1) ? '0 : id + IdW'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // First asserted request at or above the RR pointer, wrapping.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!win_vld && req_i[(int'(rr_q) + i) % NumReq]) begin
        win_vld = 1'b1;
        win     = IdW'((int'(rr_q) + i) % NumReq);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    sel        = win;
    data_req_o = 1'b0;
    gnt_o      = '0;
    case (state_q)
      ARB: begin
        if (win_vld && cnt_q < CntW'(MaxOutstanding)) begin
          data_req_o = 1'b1;
          if (data_gnt_i) begin
            gnt_o[win] = 1'b1;
            rr_d       = id_inc(win);
          end else begin
            lock_d  = win;
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        sel     = lock_q;
        state_d = ARB;
        // A locked requester that withdraws simply loses the lock.
        if (req_i[lock_q]) begin
          data_req_o = 1'b1;
          if (data_gnt_i) begin
            gnt_o[lock_q] = 1'b1;
            rr_d          = id_inc(lock_q);
          end else begin
            state_d = LOCK;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign data_we_o    = we_i[sel];
  assign data_be_o    = be_i[int'(sel)*4 +: 4];
  assign data_addr_o  = addr_i[int'(sel)*32 +: 32];
  assign data_wdata_o = wdata_i[int'(sel)*32 +: 32];

  assign push = data_req_o & data_gnt_i;
  assign pop  = data_rvalid_i && (cnt_q != '0);
  assign head = fifo_q[rptr_q];

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    if (pop) begin
      rvalid_o[head] = 1'b1;
      err_o[head]    = data_err_i;
    end
  end

  assign rdata_o    = data_rdata_i;
  assign busy_o     = (cnt_q != '0) || (state_q == LOCK);
  assign spurious_o = spurious_q;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      rr_q       <= '0;
      lock_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CntW'(1);
      if (data_rvalid_i && cnt_q == '0) spurious_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vcve2_vrf_mem_arbiter.sv
// Bench for vcve2_vrf_mem_arbiter: directed literal checks plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_vcve2_vrf_mem_arbiter;
  localparam int NR = 2;
  localparam int MO = 2;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_i, we_i;
  logic [NR*4-1:0]   be_i;
  logic [NR*32-1:0]  addr_i, wdata_i;
  logic [NR-1:0]     gnt_o, rvalid_o, err_o;
  logic [31:0]       rdata_o, data_addr_o, data_wdata_o, data_rdata_i;
  logic              data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [3:0]        data_be_o;
  logic              busy_o, spurious_o;

  int n_checks = 0;
  int n_errors = 0;

  vcve2_vrf_mem_arbiter #(.NumReq(NR), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .err_o(err_o), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .busy_o(busy_o), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending (locked) requester, RR pointer, queue of issued IDs.
  bit          mdl_on = 0;
  int          pend = -1;
  int          rr = 0;
  int          q[$];
  bit          spur = 0;
  logic [NR-1:0] mgnt = '0;

  always @(negedge clk) begin
    logic [NR-1:0] eg, erv, eer;
    bit ereq, ebusy, found;
    int esel;
    if (mdl_on) begin
      eg = '0; erv = '0; eer = '0; ereq = 0; esel = 0; found = 0;
      ebusy = (q.size() != 0) || (pend >= 0);
      if (pend >= 0) begin
        if (req_i[pend]) begin ereq = 1; esel = pend; end
        else pend = -1;
      end else if (q.size() < MO) begin
        for (int k = 0; k < NR; k++)
          if (!found && req_i[(rr + k) % NR]) begin
            found = 1; ereq = 1; esel = (rr + k) % NR;
          end
      end
      if (ereq && data_gnt_i) eg[esel] = 1'b1;
      if (data_rvalid_i && q.size() > 0) begin
        erv[q[0]] = 1'b1;
        eer[q[0]] = data_err_i;
      end
      chk("m_req", 32'(data_req_o), 32'(ereq));
      chk("m_gnt", 32'(gnt_o), 32'(eg));
      chk("m_rvalid", 32'(rvalid_o), 32'(erv));
      chk("m_err", 32'(err_o), 32'(eer));
      chk("m_rdata", rdata_o, data_rdata_i);
      chk("m_busy", 32'(busy_o), 32'(ebusy));
      chk("m_spurious", 32'(spurious_o), 32'(spur));
      if (ereq) begin
        chk("m_addr", data_addr_o, addr_i[esel*32 +: 32]);
        chk("m_wdata", data_wdata_o, wdata_i[esel*32 +: 32]);
        chk("m_be", 32'(data_be_o), 32'(be_i[esel*4 +: 4]));
        chk("m_we", 32'(data_we_o), 32'(we_i[esel]));
      end
      if (data_rvalid_i) begin
        if (q.size() > 0) void'(q.pop_front());
        else spur = 1;
      end
      if (ereq && data_gnt_i) begin
        q.push_back(esel);
        rr = (esel + 1) % NR;
        pend = -1;
      end else if (ereq) begin
        pend = esel;
      end
      mgnt = eg;
    end
    if (rst_i === 1'b1) begin
      mdl_on = 1; pend = -1; rr = 0; q.delete(); spur = 0; mgnt = '0;
    end
  end

  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic [NR-1:0] r, input logic g, input logic rv, input logic er);
    req_i = r; data_gnt_i = g; data_rvalid_i = rv; data_err_i = er;
  endtask

  initial begin
    rst_i = 1'b1;
    drv('0, 0, 0, 0);
    we_i = 2'b10; be_i = {4'hC, 4'h3};
    addr_i  = {32'hB000_0004, 32'hA000_0000};
    wdata_i = {32'h1111_2222, 32'h3333_4444};
    data_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(data_req_o), 0); chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0); chk("rst_busy", 32'(busy_o), 0);
    chk("rst_spur", 32'(spurious_o), 0);

    // Round-robin alternation with responses one cycle behind
    nx(); drv(2'b11, 1, 0, 0); @(negedge clk);
    chk("rr_g0", 32'(gnt_o), 32'h1); chk("rr_addr0", data_addr_o, 32'hA000_0000);
    nx(); drv(2'b11, 1, 1, 0); @(negedge clk);
    chk("rr_g1", 32'(gnt_o), 32'h2); chk("rr_rv0", 32'(rvalid_o), 32'h1);
    chk("rr_we1", 32'(data_we_o), 1);
    nx(); @(negedge clk);
    chk("rr_g2", 32'(gnt_o), 32'h1); chk("rr_rv1", 32'(rvalid_o), 32'h2);
    nx(); drv(2'b00, 0, 1, 0); @(negedge clk);
    chk("rr_rv2", 32'(rvalid_o), 32'h1);

    // Lock: requester 1 stalled while requester 0 joins
    nx(); drv(2'b10, 1, 0, 0); @(negedge clk);
    chk("lk_pre", 32'(gnt_o), 32'h2);
    nx(); drv(2'b10, 0, 1, 0); @(negedge clk);
    chk("lk_addr1", data_addr_o, 32'hB000_0004); chk("lk_rv", 32'(rvalid_o), 32'h2);
    nx(); drv(2'b11, 0, 0, 0); @(negedge clk);
    chk("lk_addr2", data_addr_o, 32'hB000_0004); chk("lk_busy", 32'(busy_o), 1);
    nx(); @(negedge clk);
    chk("lk_addr3", data_addr_o, 32'hB000_0004);
    nx(); drv(2'b11, 1, 0, 0); @(negedge clk);
    chk("lk_gnt", 32'(gnt_o), 32'h2);
    nx(); drv(2'b01, 1, 0, 0); @(negedge clk);
    chk("lk_next", 32'(gnt_o), 32'h1);

    // Throttle at MaxOutstanding
    nx(); drv(2'b11, 1, 0, 0); @(negedge clk);
    chk("th_req", 32'(data_req_o), 0); chk("th_gnt", 32'(gnt_o), 0);
    nx(); drv(2'b11, 1, 1, 0); @(negedge clk);
    chk("th_req2", 32'(data_req_o), 0); chk("th_rv", 32'(rvalid_o), 32'h2);
    nx(); drv(2'b11, 1, 0, 0); @(negedge clk);
    chk("th_resume", 32'(data_req_o), 1); chk("th_g", 32'(gnt_o), 32'h2);

    // Simultaneous push/pop across FIFO wrap
    nx(); drv(2'b11, 1, 1, 0); @(negedge clk);
    chk("pp_rv0", 32'(rvalid_o), 32'h1); chk("pp_req0", 32'(data_req_o), 0);
    nx(); @(negedge clk);
    chk("pp_g1", 32'(gnt_o), 32'h1); chk("pp_rv1", 32'(rvalid_o), 32'h2);
    nx(); @(negedge clk);
    chk("pp_g2", 32'(gnt_o), 32'h2); chk("pp_rv2", 32'(rvalid_o), 32'h1);
    nx(); drv(2'b00, 0, 1, 0); @(negedge clk);
    chk("pp_rv3", 32'(rvalid_o), 32'h2);
    nx(); drv(2'b00, 0, 0, 0); @(negedge clk);
    chk("pp_idle", 32'(busy_o), 0);

    // Error routing
    nx(); drv(2'b10, 1, 0, 0); @(negedge clk);
    chk("er_g", 32'(gnt_o), 32'h2);
    nx(); drv(2'b00, 0, 1, 1); data_rdata_i = 32'hDEAD_BEEF; @(negedge clk);
    chk("er_rv", 32'(rvalid_o), 32'h2); chk("er_err", 32'(err_o), 32'h2);
    chk("er_rdata", rdata_o, 32'hDEAD_BEEF);

    // Reset drops in-flight IDs; late response is spurious
    nx(); drv(2'b01, 1, 0, 0); @(negedge clk);
    chk("sp_g", 32'(gnt_o), 32'h1);
    nx(); rst_i = 1'b1; drv(2'b00, 0, 0, 0);
    nx(); rst_i = 1'b0; drv(2'b00, 0, 1, 0); @(negedge clk);
    chk("sp_rv", 32'(rvalid_o), 0); chk("sp_pre", 32'(spurious_o), 0);
    nx(); drv(2'b00, 0, 0, 0); @(negedge clk);
    chk("sp_set", 32'(spurious_o), 1);
    nx(); @(negedge clk);
    chk("sp_hold", 32'(spurious_o), 1);

    // Randomized traffic; requesters hold their request until granted
    for (int c = 0; c < 3000; c++) begin
      nx();
      rst_i = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!(req_i[i] && !mgnt[i])) begin
          req_i[i] = ($urandom_range(0, 2) != 0);
          we_i[i] = 1'($urandom_range(0, 1));
          be_i[i*4 +: 4] = 4'($urandom);
          addr_i[i*32 +: 32] = $urandom;
          wdata_i[i*32 +: 32] = $urandom;
        end
      end
      data_gnt_i    = ($urandom_range(0, 1) == 1);
      data_rvalid_i = ($urandom_range(0, 4) < 2);
      data_err_i    = 1'($urandom_range(0, 1));
      data_rdata_i  = $urandom;
    end
    nx(); rst_i = 1'b0; drv('0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
